// File: rtl/branch_fetch_ctrl.sv
// Sequencing controller for the instruction datapath: FETCH/DECODE/EXEC loop over a
// req/ack instruction memory, branch decode, PC gating, NZCV flags, retire count, fetch timeout.
module branch_fetch_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  input  logic             cbz_zero,
  input  logic             set_flags,
  input  logic [3:0]       alu_nzcv,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             UncondBr,
  output logic             BrTaken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_FAULT} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [31:0]        instr_q, instr_d;
  logic [3:0]         flags_q, flags_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               br_uncond_q, br_uncond_d;
  logic               br_taken_q, br_taken_d;
  logic               br_cbz_q, br_cbz_d;
  logic               commit;

  // Conditions come in complementary pairs: cc[3:1] picks the test, cc[0] inverts it
  // (except 4'hE/4'hF, which are both "always").
  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv;
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cc[3:1] != 3'b111 && cc[0]) ? ~base : base;
  endfunction

  assign commit = (state_q == S_EXEC) && !dmem_busy;

  always_ff @(posedge clk) begin
    // NOTE: every flop uses non-blocking assignment so all state updates see pre-edge values.
    if (reset) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      instr_q     <= '0;
      flags_q     <= '0;
      retired_q   <= '0;
      br_uncond_q <= 1'b0;
      br_taken_q  <= 1'b0;
      br_cbz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      instr_q     <= instr_d;
      flags_q     <= flags_d;
      retired_q   <= retired_d;
      br_uncond_q <= br_uncond_d;
      br_taken_q  <= br_taken_d;
      br_cbz_q    <= br_cbz_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack)                                 state_d = S_DECODE;
        else if (wait_q == WAIT_W'(TIMEOUT - 1))      state_d = S_FAULT;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   if (!dmem_busy) state_d = S_FETCH;
      default:  state_d = S_FAULT;
    endcase
  end

  always_comb begin
    wait_d      = (state_q == S_FETCH && !imem_ack) ? wait_q + WAIT_W'(1) : '0;
    instr_d     = (state_q == S_FETCH && imem_ack) ? imem_rdata : instr_q;
    flags_d     = (commit && set_flags) ? alu_nzcv : flags_q;
    retired_d   = commit ? retired_q + CNT_W'(1) : retired_q;
    br_uncond_d = br_uncond_q;
    br_taken_d  = br_taken_q;
    br_cbz_d    = br_cbz_q;
    if (state_q == S_DECODE) begin
      br_uncond_d = (instr_q[31:26] == 6'b000101);
      br_cbz_d    = (instr_q[31:24] == 8'hB4);
      br_taken_d  = br_uncond_d ||
                    ((instr_q[31:24] == 8'h54) && !instr_q[4] && cond_holds(instr_q[3:0], flags_q));
    end
  end

  // Branch controls are only meaningful in the commit cycle; CBZ uses cbz_zero live there.
  always_comb begin
    imem_req = 1'b0;
    pc_en    = 1'b0;
    UncondBr = 1'b0;
    BrTaken  = 1'b0;
    fault    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_EXEC: begin
          if (!dmem_busy) begin
            pc_en    = 1'b1;
            UncondBr = br_uncond_q;
            BrTaken  = br_cbz_q ? cbz_zero : br_taken_q;
          end
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr   = instr_q;
  assign flags   = flags_q;
  assign retired = retired_q;

endmodule
